// File: rtl/arbitro_ula.sv
// Two-requester round-robin arbiter that time-shares one external ALU and
// returns each result over a single valid/ready response channel.
module arbitro_ula #(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0_valido,
  input  logic               req1_valido,
  output logic               req0_pronto,
  output logic               req1_pronto,
  input  logic [3:0]         req0_op,
  input  logic [3:0]         req1_op,
  input  logic [LARGURA-1:0] req0_a,
  input  logic [LARGURA-1:0] req0_b,
  input  logic [LARGURA-1:0] req1_a,
  input  logic [LARGURA-1:0] req1_b,
  output logic [3:0]         ula_controle,
  output logic [LARGURA-1:0] ula_dados1,
  output logic [LARGURA-1:0] ula_dados2,
  input  logic [LARGURA-1:0] ula_saida,
  input  logic               ula_zero,
  output logic               resp_valido,
  input  logic               resp_pronto,
  output logic               resp_id,
  output logic [LARGURA-1:0] resp_resultado,
  output logic               resp_zero,
  output logic               resp_erro,
  output logic [15:0]        contador_ops
);

  typedef enum logic [1:0] {OCIOSO, EXECUTA, RESPONDE} estado_t;

  estado_t              estado_q, estado_d;
  logic                 prioridade_q;
  logic [3:0]           op_q;
  logic [LARGURA-1:0]   a_q, b_q;
  logic                 id_q;
  logic [LARGURA-1:0]   resultado_q;
  logic                 zero_q, erro_q, resp_id_q;
  logic [15:0]          contador_q;
  logic                 vencedor, concede, op_invalido;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    vencedor = req1_valido;
    if (req0_valido && req1_valido) vencedor = prioridade_q;
  end

  assign concede = (estado_q == OCIOSO) && (req0_valido || req1_valido);

  always_comb begin
    op_invalido = 1'b1;
    if (op_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111}) op_invalido = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado_q <= OCIOSO;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:   if (concede) estado_d = EXECUTA;
      EXECUTA:  estado_d = RESPONDE;
      RESPONDE: if (resp_pronto) estado_d = OCIOSO;
      default:  estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    req0_pronto  = concede && !vencedor;
    req1_pronto  = concede && vencedor;
    resp_valido  = (estado_q == RESPONDE);
    ula_controle = '0;
    ula_dados1   = '0;
    ula_dados2   = '0;
    if (estado_q == EXECUTA) begin
      ula_controle = op_q;
      ula_dados1   = a_q;
      ula_dados2   = b_q;
    end
  end

  // Payload is only rewritten on the ALU cycle, so it survives the handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prioridade_q <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      resultado_q  <= '0;
      zero_q       <= 1'b0;
      erro_q       <= 1'b0;
      resp_id_q    <= 1'b0;
      contador_q   <= '0;
    end else begin
      if (concede) begin
        op_q         <= vencedor ? req1_op : req0_op;
        a_q          <= vencedor ? req1_a  : req0_a;
        b_q          <= vencedor ? req1_b  : req0_b;
        id_q         <= vencedor;
        prioridade_q <= ~vencedor;
      end
      if (estado_q == EXECUTA) begin
        resultado_q <= ula_saida;
        zero_q      <= ula_zero;
        erro_q      <= op_invalido;
        resp_id_q   <= id_q;
      end
      if (resp_valido && resp_pronto) contador_q <= contador_q + 16'd1;
    end
  end

  assign resp_id        = resp_id_q;
  assign resp_resultado = resultado_q;
  assign resp_zero      = zero_q;
  assign resp_erro      = erro_q;
  assign contador_ops   = contador_q;

endmodule

// File: tb/tb_arbitro_ula.sv
// Randomized + directed bench for arbitro_ula: a monitor predicts grants and
// responses from the arbitration rules and scores every response handshake.
module tb_arbitro_ula;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         v  [2];
  logic [3:0]   op [2];
  logic [W-1:0] a  [2];
  logic [W-1:0] b  [2];
  logic         req0_pronto, req1_pronto;
  logic [3:0]   ula_controle;
  logic [W-1:0] ula_dados1, ula_dados2, ula_saida;
  logic         ula_zero;
  logic         resp_valido, resp_pronto, resp_id, resp_zero, resp_erro;
  logic [W-1:0] resp_resultado;
  logic [15:0]  contador_ops;

  arbitro_ula #(.LARGURA(W)) dut (
    .clock(clock), .reset(reset),
    .req0_valido(v[0]), .req1_valido(v[1]),
    .req0_pronto(req0_pronto), .req1_pronto(req1_pronto),
    .req0_op(op[0]), .req1_op(op[1]),
    .req0_a(a[0]), .req0_b(b[0]), .req1_a(a[1]), .req1_b(b[1]),
    .ula_controle(ula_controle), .ula_dados1(ula_dados1), .ula_dados2(ula_dados2),
    .ula_saida(ula_saida), .ula_zero(ula_zero),
    .resp_valido(resp_valido), .resp_pronto(resp_pronto), .resp_id(resp_id),
    .resp_resultado(resp_resultado), .resp_zero(resp_zero), .resp_erro(resp_erro),
    .contador_ops(contador_ops)
  );

  function automatic logic [W-1:0] alu(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    case (c)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0111: return ($signed(x) < $signed(y)) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  // The shared ALU the arbiter drives.
  assign ula_saida = alu(ula_controle, ula_dados1, ula_dados2);
  assign ula_zero  = (ula_saida == '0);

  typedef struct {
    logic         id;
    logic [3:0]   op;
    logic [W-1:0] a, b, res;
    logic         zero, erro;
  } exp_t;

  exp_t sb[$];
  int   win[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, exp_rv = -1, exp_ex = -1;
  int   gcnt [2] = '{0, 0};
  bit   ptr, busy, prev_rv, hs_pend;
  logic [15:0] hs_val;
  logic [3:0] okl [5] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, ex, $time);
    end
  endtask

  function automatic exp_t mk(input int k);
    exp_t e;
    e.id   = k[0];
    e.op   = op[k];
    e.a    = a[k];
    e.b    = b[k];
    e.res  = alu(op[k], a[k], b[k]);
    e.zero = (e.res == '0);
    e.erro = !(op[k] inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7});
    return e;
  endfunction

  // Monitor: one operation outstanding at a time, round-robin tie-break,
  // response two cycles after grant, counter +1 per handshake.
  always @(negedge clock) begin : mon
    bit w, ew;
    logic [15:0] nx;
    if (reset) begin
      sb.delete();
      ptr = 0; busy = 0; prev_rv = 0; hs_pend = 0; exp_rv = -1; exp_ex = -1;
    end else begin
      cyc++;
      if (hs_pend) begin
        nx = hs_val + 16'd1;
        chk("contador_inc", contador_ops, nx);
        hs_pend = 0;
      end
      if (req0_pronto || req1_pronto) begin
        w  = req1_pronto;
        ew = (v[0] && v[1]) ? ptr : v[1];
        chk("grant_onehot", req0_pronto && req1_pronto, 0);
        chk("grant_idle", busy, 0);
        chk("grant_valid", w ? v[1] : v[0], 1);
        chk("grant_who", w, ew);
        ptr = !w;
        sb.push_back(mk(w));
        busy = 1;
        gcnt[w]++;
        win.push_back(w);
        exp_ex = cyc + 1;
        exp_rv = cyc + 2;
      end else if (!busy && (v[0] || v[1])) begin
        chk("grant_missing", req0_pronto | req1_pronto, 1);
      end
      if (cyc == exp_ex && sb.size() > 0) begin
        chk("ula_op", ula_controle, sb[0].op);
        chk("ula_a", ula_dados1, sb[0].a);
        chk("ula_b", ula_dados2, sb[0].b);
      end else begin
        chk("ula_idle", |{ula_controle, ula_dados1, ula_dados2}, 0);
      end
      if (cyc == exp_rv) chk("latency", {prev_rv, resp_valido}, 2'b01);
      if (resp_valido) begin
        if (sb.size() == 0) chk("resp_unexpected", resp_valido, 0);
        else begin
          chk("resp_id", resp_id, sb[0].id);
          chk("resp_res", resp_resultado, sb[0].res);
          chk("resp_zero", resp_zero, sb[0].zero);
          chk("resp_erro", resp_erro, sb[0].erro);
          if (resp_pronto) begin
            hs_pend = 1;
            hs_val  = contador_ops;
            void'(sb.pop_front());
            busy = 0;
          end
        end
      end
      prev_rv = resp_valido;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic setreq(input int k, input logic vv, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    v[k] = vv; op[k] = o; a[k] = x; b[k] = y;
  endtask

  task automatic rnd(input int k);
    op[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : okl[$urandom_range(0, 4)];
    a[k]  = $urandom;
    b[k]  = ($urandom_range(0, 3) == 0) ? a[k] : $urandom;
  endtask

  task automatic wait_grant(input int k);
    int s, t;
    s = gcnt[k]; t = 0;
    while (gcnt[k] == s && t < 50) begin @(posedge clock); t++; end
    #1;
    chk("grant_timeout", gcnt[k] != s, 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin @(posedge clock); t++; end while (busy && t < 60);
    #1;
    chk("idle_timeout", busy, 0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk(nm, |{req0_pronto, req1_pronto, resp_valido, resp_id, resp_resultado, resp_zero,
              resp_erro, ula_controle, ula_dados1, ula_dados2, contador_ops}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int s, t, seen [2];
    logic [15:0] ew;
    reset = 1'b1; resp_pronto = 1'b0;
    for (int k = 0; k < 2; k++) setreq(k, 0, 4'd0, '0, '0);
    cycles(3);
    chk_reset_outputs("reset_state");
    reset = 1'b0;

    // req0 alone: 5 + 7
    resp_pronto = 1'b1;
    setreq(0, 1, 4'b0010, 5, 7);
    wait_grant(0);
    setreq(0, 0, 4'b0010, 5, 7);
    wait_idle();
    chk("add_res", resp_resultado, 12);
    chk("add_id", resp_id, 0);
    chk("add_zero_erro", {resp_zero, resp_erro}, 2'b00);
    chk("add_count", contador_ops, 1);

    // Both always valid: req0 just won, so grants run 1,0,1,0
    setreq(0, 1, 4'b0110, 9, 9);
    setreq(1, 1, 4'b0110, 9, 9);
    s = win.size(); t = 0;
    while (win.size() < s + 4 && t < 60) begin @(posedge clock); t++; end
    #1;
    setreq(0, 0, 4'b0110, 9, 9);
    setreq(1, 0, 4'b0110, 9, 9);
    wait_idle();
    chk("alt_count", win.size(), s + 4);
    for (int i = 0; i < 4; i++) chk("alt_grant", win[s+i], (i % 2 == 0) ? 1 : 0);

    // Stalled response must hold while req0 waits
    resp_pronto = 1'b0;
    setreq(1, 1, 4'b0111, 3, 8);
    wait_grant(1);
    setreq(1, 0, 4'b0000, '1, '1);
    setreq(0, 1, 4'b0001, 4, 4);
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      chk("stall_valid", resp_valido, 1);
      chk("stall_payload", {resp_id, resp_resultado}, {1'b1, 32'd1});
    end
    setreq(0, 0, 4'b0001, 4, 4);
    resp_pronto = 1'b1;
    wait_idle();

    // Unsupported op
    setreq(0, 1, 4'b1111, 32'hFFFF_FFFF, 1);
    wait_grant(0);
    setreq(0, 0, 4'b1111, 0, 0);
    wait_idle();
    chk("bad_op", {resp_resultado, resp_zero, resp_erro}, {32'd0, 1'b1, 1'b1});

    // Reset while the response is pending
    resp_pronto = 1'b0;
    setreq(1, 1, 4'b0010, 1, 1);
    wait_grant(1);
    setreq(1, 0, 4'b0010, 1, 1);
    cycles(2);
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    chk_reset_outputs("reset_mid");
    cycles(2);
    reset = 1'b0;
    resp_pronto = 1'b1;
    setreq(0, 1, 4'b0000, 6, 3);
    setreq(1, 1, 4'b0000, 6, 3);
    s = win.size(); t = 0;
    while (win.size() == s && t < 20) begin @(posedge clock); t++; end
    #1;
    setreq(0, 0, 4'b0000, 0, 0);
    setreq(1, 0, 4'b0000, 0, 0);
    wait_idle();
    chk("post_reset_grant", win[s], 0);
    chk("post_reset_count", contador_ops, 1);

    // Random traffic with random back-pressure
    seen[0] = gcnt[0]; seen[1] = gcnt[1];
    for (int c = 0; c < 1500; c++) begin
      cycles(1);
      resp_pronto = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 2; k++) begin
        if (gcnt[k] != seen[k]) begin
          seen[k] = gcnt[k];
          v[k] = 1'($urandom_range(0, 1));
          rnd(k);
        end else if (!v[k]) begin
          v[k] = ($urandom_range(0, 2) == 0);
          rnd(k);
        end else if ($urandom_range(0, 3) == 0) begin
          rnd(k);
        end
      end
    end
    v[0] = 1'b0; v[1] = 1'b0; resp_pronto = 1'b1;
    wait_idle();

    // Counter wrap: preload near the top rather than run 65536 operations
    cycles(2);
    @(negedge clock);
    dut.contador_q <= 16'hFFFD;
    cycles(1);
    chk("preload", contador_ops, 16'hFFFD);
    for (int i = 0; i < 3; i++) begin
      setreq(0, 1, 4'b0010, i, i);
      wait_grant(0);
      setreq(0, 0, 4'b0010, 0, 0);
      wait_idle();
      ew = 16'hFFFE + 16'(i);
      chk("wrap", contador_ops, ew);
    end

    cycles(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
